// File: rtl/tt_vpu_ovi_mon_pkg.sv
// Shared types for the OVI protocol monitor: error codes, first-error
// record and the same-cycle priority helper.
package tt_vpu_ovi_mon_pkg;

   localparam int N_ERR       = 8;
   // Capture record holds IDs up to this width; the monitor requires SB_W <= SB_ID_MAX_W.
   localparam int SB_ID_MAX_W = 8;

   typedef enum logic [2:0] {
      ERR_ISSUE_NO_CREDIT     = 3'd0,
      ERR_CREDIT_OVERFLOW     = 3'd1,
      ERR_ISSUE_DUP_SB        = 3'd2,
      ERR_DISPATCH_UNKNOWN_SB = 3'd3,
      ERR_KILL_AND_SENIOR     = 3'd4,
      ERR_COMPLETE_UNKNOWN_SB = 3'd5,
      ERR_COMPLETE_NOT_SENIOR = 3'd6,
      ERR_WATCHDOG            = 3'd7
   } err_code_e;

   typedef struct packed {
      logic                   valid;
      err_code_e              code;
      logic [SB_ID_MAX_W-1:0] sb_id;
   } first_err_t;

   // Lowest set error code wins when several fire in one cycle.
   function automatic err_code_e lowest_err(input logic [N_ERR-1:0] errs);
      err_code_e c;
      c = ERR_WATCHDOG;
      for (int i = N_ERR - 1; i >= 0; i--) begin
         if (errs[i]) c = err_code_e'(i[2:0]);
      end
      return c;
   endfunction

endpackage

// File: rtl/tt_vpu_ovi_mon_sbtable.sv
// Per-scoreboard-ID live/senior tracking with registered live count.
module tt_vpu_ovi_mon_sbtable #(
   parameter int SB_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_en,
   input  logic [SB_W-1:0] issue_id,
   input  logic            senior_en,
   input  logic            kill_en,
   input  logic [SB_W-1:0] dispatch_id,
   input  logic            comp_en,
   input  logic [SB_W-1:0] comp_id,
   output logic            issue_live,
   output logic            dispatch_live,
   output logic            comp_live,
   output logic            comp_senior,
   output logic [SB_W:0]   outstanding
);

   localparam int DEPTH = 1 << SB_W;

   logic [DEPTH-1:0] live_q, live_d;
   logic [DEPTH-1:0] senior_q, senior_d;
   logic [SB_W:0]    outstanding_q, outstanding_d;

   // Lookups see the registered (pre-cycle) table.
   assign issue_live    = live_q[issue_id];
   assign dispatch_live = live_q[dispatch_id];
   assign comp_live     = live_q[comp_id];
   assign comp_senior   = senior_q[comp_id];
   assign outstanding   = outstanding_q;

   // Clears first, then senior set, then issue: a new issue to an ID that is
   // being retired in the same cycle leaves a fresh, non-senior live entry.
   always_comb begin
      live_d   = live_q;
      senior_d = senior_q;
      if (kill_en)   live_d[dispatch_id] = 1'b0;
      if (comp_en)   live_d[comp_id]     = 1'b0;
      if (senior_en) senior_d[dispatch_id] = 1'b1;
      if (issue_en) begin
         live_d[issue_id]   = 1'b1;
         senior_d[issue_id] = 1'b0;
      end
      outstanding_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         outstanding_d = outstanding_d + (SB_W+1)'(live_d[i]);
      end
   end

   // Table and count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         live_q        <= '0;
         senior_q      <= '0;
         outstanding_q <= '0;
      end else begin
         live_q        <= live_d;
         senior_q      <= senior_d;
         outstanding_q <= outstanding_d;
      end
   end

endmodule

// File: rtl/tt_vpu_ovi_monitor.sv
// Open Vector Interface protocol monitor: credit tracking, scoreboard ID
// lifecycle checks and sticky/pulse/first-error reporting.
// Optional completion watchdog enabled by defining TT_VPU_OVI_MON_WATCHDOG_EN.
module tt_vpu_ovi_monitor #(
   parameter int SB_W        = 5,
   parameter int MAX_CREDITS = 16,
   parameter int TIMEOUT     = 1024
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               issue_valid,
   input  logic [SB_W-1:0]                    issue_sb_id,
   input  logic                               issue_credit,
   input  logic                               dispatch_next_senior,
   input  logic                               dispatch_kill,
   input  logic [SB_W-1:0]                    dispatch_sb_id,
   input  logic                               completed_valid,
   input  logic [SB_W-1:0]                    completed_sb_id,
   input  logic                               clr_err,
   output logic [7:0]                         err_sticky,
   output logic                               err_pulse,
   output logic [2:0]                         first_err_code,
   output logic [SB_W-1:0]                    first_err_sb_id,
   output logic                               first_err_valid,
   output logic [$clog2(MAX_CREDITS+1)-1:0]   credits,
   output logic [SB_W:0]                      outstanding
);
   import tt_vpu_ovi_mon_pkg::*;

   localparam int              CRED_W     = $clog2(MAX_CREDITS + 1);
   localparam logic [CRED_W-1:0] MAX_CRED_V = CRED_W'(MAX_CREDITS);

   logic [CRED_W-1:0] credits_q, credits_d;
   logic [N_ERR-1:0]  sticky_q, sticky_d;
   logic              pulse_q, pulse_d;
   first_err_t        rec_q, rec_d;
   logic [N_ERR-1:0]  errs;
   logic              issue_live, dispatch_live, comp_live, comp_senior;
   logic              legal_comp_same, legal_kill_same;
   logic              wd_fire;
   logic              rec_sb_unused;

   tt_vpu_ovi_mon_sbtable #(.SB_W(SB_W)) u_sbtable (
      .clk           (clk),
      .reset         (reset),
      .issue_en      (issue_valid),
      .issue_id      (issue_sb_id),
      .senior_en     (dispatch_next_senior),
      .kill_en       (dispatch_kill),
      .dispatch_id   (dispatch_sb_id),
      .comp_en       (completed_valid),
      .comp_id       (completed_sb_id),
      .issue_live    (issue_live),
      .dispatch_live (dispatch_live),
      .comp_live     (comp_live),
      .comp_senior   (comp_senior),
      .outstanding   (outstanding)
   );

`ifdef TT_VPU_OVI_MON_WATCHDOG_EN
   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [WD_W-1:0] wd_q, wd_d;

   // Cycles since the last completion while IDs are live; fires once on
   // reaching TIMEOUT-1 and then holds until a completion or empty table.
   always_comb begin
      wd_d    = wd_q;
      wd_fire = 1'b0;
      if (completed_valid || outstanding == '0) begin
         wd_d = '0;
      end else if (wd_q != WD_W'(TIMEOUT - 1)) begin
         wd_d    = wd_q + 1'b1;
         wd_fire = (wd_d == WD_W'(TIMEOUT - 1));
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk) begin
      if (reset) wd_q <= '0;
      else       wd_q <= wd_d;
   end
`else
   localparam int TIMEOUT_UNUSED = TIMEOUT;
   assign wd_fire = 1'b0;
`endif

   // Protocol checks against pre-cycle state; the duplicate-issue check also
   // accepts an ID being legally retired in the same cycle.
   always_comb begin
      legal_comp_same = completed_valid && (completed_sb_id == issue_sb_id) && comp_live && comp_senior;
      legal_kill_same = dispatch_kill && !dispatch_next_senior && (dispatch_sb_id == issue_sb_id) && dispatch_live;
      errs    = '0;
      errs[0] = issue_valid && (credits_q == '0);
      errs[1] = issue_credit && !issue_valid && (credits_q == MAX_CRED_V);
      errs[2] = issue_valid && issue_live && !legal_comp_same && !legal_kill_same;
      errs[3] = (dispatch_next_senior || dispatch_kill) && !dispatch_live;
      errs[4] = dispatch_next_senior && dispatch_kill;
      errs[5] = completed_valid && !comp_live;
      errs[6] = completed_valid && comp_live && !comp_senior;
      errs[7] = wd_fire;
   end

   // Credit count clamps at both ends: an overflowing return is dropped and
   // an issue without credit cannot wrap the count below zero.
   always_comb begin
      credits_d = credits_q;
      if (issue_credit && !issue_valid) begin
         if (credits_q != MAX_CRED_V) credits_d = credits_q + 1'b1;
      end else if (issue_valid && !issue_credit) begin
         if (credits_q != '0) credits_d = credits_q - 1'b1;
      end
   end

   // Error reporting; errors seen in a clearing cycle survive the clear.
   always_comb begin
      pulse_d  = (errs != '0);
      sticky_d = clr_err ? errs : (sticky_q | errs);
      rec_d    = clr_err ? '0 : rec_q;
      if ((errs != '0) && (clr_err || !rec_q.valid)) begin
         rec_d.valid = 1'b1;
         rec_d.code  = lowest_err(errs);
         case (rec_d.code)
            ERR_ISSUE_NO_CREDIT, ERR_CREDIT_OVERFLOW, ERR_ISSUE_DUP_SB:
               rec_d.sb_id = SB_ID_MAX_W'(issue_sb_id);
            ERR_DISPATCH_UNKNOWN_SB, ERR_KILL_AND_SENIOR:
               rec_d.sb_id = SB_ID_MAX_W'(dispatch_sb_id);
            ERR_COMPLETE_UNKNOWN_SB, ERR_COMPLETE_NOT_SENIOR:
               rec_d.sb_id = SB_ID_MAX_W'(completed_sb_id);
            default:
               rec_d.sb_id = '0;
         endcase
      end
   end

   // Output and credit registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits_q <= '0;
         sticky_q  <= '0;
         pulse_q   <= 1'b0;
         rec_q     <= '0;
      end else begin
         credits_q <= credits_d;
         sticky_q  <= sticky_d;
         pulse_q   <= pulse_d;
         rec_q     <= rec_d;
      end
   end

   // Capture bits above SB_W are always zero.
   assign rec_sb_unused   = ^rec_q.sb_id;
   assign err_sticky      = sticky_q;
   assign err_pulse       = pulse_q;
   assign first_err_code  = rec_q.code;
   assign first_err_sb_id = rec_q.sb_id[SB_W-1:0];
   assign first_err_valid = rec_q.valid;
   assign credits         = credits_q;

endmodule
